// File: rtl/serialc.sv
// ---------------------------------------------------------------------------
// serialc : 8N1 asynchronous serial receiver (console decoder)
//
// Receives frames on RXD that are 1 start bit, 8 data bits (LSB first) and
// 1 stop bit. Each bit lasts SERIAL_WCNT clock cycles. Every frame with a
// valid stop bit produces a one-cycle EN strobe with the byte on DATA.
//
// Parameters:
//   SERIAL_WCNT  clock cycles per serial bit (4..65535)
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_X  in   asynchronous active-low reset
//   RXD    in   serial line, idle high
//   DATA   out  last correctly received byte, held between strobes
//   EN     out  one-cycle strobe, DATA carries a new byte
//
// Build option:
//   SERIALC_SYNC_EN  when defined, RXD passes through a two-flop
//                    synchronizer (reset to 1), adding 2 cycles of latency.
//                    When undefined, RXD must be synchronous to CLK.
// ---------------------------------------------------------------------------
module serialc #(
    parameter int SERIAL_WCNT = 20
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       EN
);

    localparam int TW = $clog2(SERIAL_WCNT) + 1;

    // Sample points: the start bit is checked half a bit after the falling
    // edge, and every following sample lands one full bit later.
    localparam logic [TW-1:0] HALF_CNT = TW'(SERIAL_WCNT / 2);
    localparam logic [TW-1:0] BIT_CNT  = TW'(SERIAL_WCNT);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic          rx_s;

    logic [2:0]    state_reg,   state_next;
    logic [TW-1:0] timer_reg,   timer_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg,   shift_next;
    logic [7:0]    data_reg,    data_next;
    logic          en_reg,      en_next;

`ifdef SERIALC_SYNC_EN
    // Both flops reset to the idle level so that reset never looks like a
    // start bit.
    logic [1:0] sync_reg;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], RXD};
        end
    end

    assign rx_s = sync_reg[1];
`else
    assign rx_s = RXD;
`endif

    // The timer holds the index of the current cycle since the last sample
    // point. Reloading it with 1 when leaving a sample keeps the
    // comparisons against HALF_CNT / BIT_CNT exact.
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        en_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    timer_next = TW'(1);
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (timer_reg == HALF_CNT) begin
                    if (rx_s) begin
                        // Low pulse shorter than half a bit: treat as glitch.
                        state_next = ST_IDLE;
                        timer_next = '0;
                    end else begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                        timer_next   = TW'(1);
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_DATA: begin
                if (timer_reg == BIT_CNT) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    timer_next = TW'(1);
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_STOP: begin
                if (timer_reg == BIT_CNT) begin
                    timer_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        en_next    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        // Framing error or break: wait for the line to
                        // return high before looking for a new start bit.
                        state_next = ST_WAIT_HIGH;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
            data_reg    <= 8'h00;
            en_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            en_reg      <= en_next;
        end
    end

    assign DATA = data_reg;
    assign EN   = en_reg;

endmodule

// File: tb/tb_serialc.sv
// ---------------------------------------------------------------------------
// tb_serialc : bench for the serialc receiver.
// Stimulus drives frames bit by bit and pushes the expected byte into a
// queue; a monitor pops and compares on every EN strobe.
// ---------------------------------------------------------------------------
module tb_serialc;

    localparam int T = 20;

`ifdef SERIALC_SYNC_EN
    localparam int FIRST_LAT = 10 + 9 * 20 + 1 + 2;
`else
    localparam int FIRST_LAT = 10 + 9 * 20 + 1;
`endif

    logic       clk;
    logic       rst_x;
    logic       rxd;
    logic [7:0] data;
    logic       en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0] data;
        int         exp_rel;
        int         start_cyc;
    } exp_t;

    exp_t sb_q[$];

    serialc #(.SERIAL_WCNT(T)) dut (
        .CLK   (clk),
        .RST_X (rst_x),
        .RXD   (rxd),
        .DATA  (data),
        .EN    (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest outstanding expectation.
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        if (en) begin
            exp_t e;
            checks++;
            if (en_prev) begin
                errors++;
                $display("FAIL en_consecutive: EN high on two cycles, cyc=%0d", cyc);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_en: got DATA=%02h, expected no strobe", data);
            end else begin
                e = sb_q.pop_front();
                if (data !== e.data) begin
                    errors++;
                    $display("FAIL rx_data: got %02h expected %02h", data, e.data);
                end else begin
                    $display("rx byte %02h ok", data);
                end
                if (e.exp_rel >= 0) begin
                    checks++;
                    if (cyc - e.start_cyc != e.exp_rel) begin
                        errors++;
                        $display("FAIL en_timing: got cycle %0d expected %0d",
                                 cyc - e.start_cyc, e.exp_rel);
                    end else begin
                        $display("strobe at cycle %0d ok", cyc - e.start_cyc);
                    end
                end
            end
        end
        en_prev <= en;
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end else begin
            $display("%s: %02h ok", name, got);
        end
    endtask

    // Called aligned to a falling clock edge; leaves RXD at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input bit push, input int exp_rel);
        exp_t e;
        e.data      = b;
        e.exp_rel   = exp_rel;
        e.start_cyc = cyc;
        if (push) sb_q.push_back(e);
        rxd = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (T) @(negedge clk);
        end
        rxd = stop_lvl;
        repeat (T) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b41;
        logic [7:0] b_stream [4];
        b41 = 8'h41;
        b_stream[0] = 8'h00;
        b_stream[1] = 8'hFF;
        b_stream[2] = 8'h55;
        b_stream[3] = 8'hAA;

        rst_x = 1'b0;
        rxd   = 1'b1;
        #1;
        check8("reset_data", data, 8'h00);
        check8("reset_en", {7'd0, en}, 8'h00);
        repeat (3) @(negedge clk);
        rst_x = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame with strobe timing.
        send_frame(8'h41, 1'b1, 1'b1, FIRST_LAT);
        repeat (2 * T) @(negedge clk);

        // Back-to-back frames, one stop bit each.
        for (int k = 0; k < 4; k++) send_frame(b_stream[k], 1'b1, 1'b1, -1);
        repeat (2 * T) @(negedge clk);

        // Start glitch, then a real frame.
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * T) @(negedge clk);
        send_frame(8'h41, 1'b1, 1'b1, -1);
        repeat (2 * T) @(negedge clk);

        // Framing error followed by a long break.
        send_frame(8'h33, 1'b0, 1'b0, -1);
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * T) @(negedge clk);
        check8("data_hold", data, 8'h41);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        repeat (2 * T) @(negedge clk);

        // Reset in the middle of data bit 4.
        rxd = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b41[i];
            repeat (T) @(negedge clk);
        end
        rxd = b41[4];
        repeat (T / 2) @(negedge clk);
        rst_x = 1'b0;
        #1;
        check8("midrst_data", data, 8'h00);
        check8("midrst_en", {7'd0, en}, 8'h00);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_x = 1'b1;
        repeat (2 * T) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b1, -1);
        repeat (2 * T + 5) @(negedge clk);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending strobes expected 0", sb_q.size());
        end else begin
            $display("queue_drain: all strobes seen");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serialc.md
Name: serialc

Overview:
- 8N1 asynchronous serial (UART) receiver; one byte is delivered per frame on the TXD line driven by the soc.
- Used in simulation to decode the soc's console output into characters.
- Each valid frame produces a one-cycle EN strobe with the received byte on DATA.

Parameters:
- SERIAL_WCNT, default 20: clock cycles per serial bit (T); legal range 4..65535.

Ports:
- CLK  input  1  system clock; all sequential logic on the rising edge.
- RST_X  input  1  reset, asynchronous, active-low.
- RXD  input  1  serial line; idle high, LSB first, 1 start bit, 8 data bits, 1 stop bit, no parity.
- DATA  output  8  last correctly received byte.
- EN  output  1  one-cycle strobe: DATA updated with a new valid byte.

Behaviour:
- Reset (RST_X=0, asynchronous):
  - DATA=0x00, EN=0, state=IDLE, bit counter=0, timer=0, shift register=0.
  - All outputs are cleared immediately, independent of CLK.
  - A frame in progress is discarded; there is no partial delivery.
- rx_s is the line value used by the FSM (see Optional Feature).
- Timer: counts CLK cycles, width ceil(log2(SERIAL_WCNT))+1 bits. "Cycle 0" is the first cycle in IDLE with rx_s=0.
- IDLE: EN=0. On rx_s=0, load the timer and go to START.
- START: at cycle floor(T/2), sample rx_s.
  - rx_s=1 (glitch): return to IDLE, no output.
  - rx_s=0: go to DATA, bit index=0.
- DATA: sample data bit i (i=0..7) at cycle floor(T/2)+(i+1)*T.
  - Shift right; bit 0 of the byte is received first.
  - After bit 7, go to STOP.
- STOP: sample rx_s at cycle floor(T/2)+9*T.
  - rx_s=1 (valid): on the next cycle DATA<=shift register and EN=1 for exactly one cycle. Go to IDLE; a new start bit can be accepted from that cycle on.
  - rx_s=0 (framing error): no EN, DATA unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: remain until rx_s=1, then go to IDLE. A held-low break never yields spurious frames.
- EN is never high on two consecutive cycles.
- DATA holds its value between strobes.
- Back-to-back frames: a start bit that begins exactly T cycles after the previous stop-bit start must be received.
- Baud tolerance: sampling at bit centres tolerates about ±4% clock mismatch over a frame.
- No other outputs. No data is buffered; a new frame overwrites DATA.

Optional Feature:
- SERIALC_SYNC_EN defined:
  - RXD passes through a two-flop synchronizer, both flops reset to 1; rx_s is the second flop.
  - All frame timings are delayed 2 cycles relative to the RXD pin.
- SERIALC_SYNC_EN undefined:
  - rx_s=RXD directly, with zero added latency.
  - RXD must be synchronous to CLK (e.g. driven by the soc's UART TX in the same clock domain).

Test Plan:
- Send 0x41 (T=20, no sync): EN high for exactly one cycle at cycle 10+9*20+1=191 after the start edge, DATA=0x41; EN low at all other times.
- Send 0x00, then 0xFF, then 0x55 and 0xAA back-to-back with exactly one stop bit each: four EN pulses, DATA=0x00, 0xFF, 0x55, 0xAA in order.
- Start glitch: RXD low for 5 cycles, then high: no EN, FSM back in IDLE; a following 0x41 is received correctly.
- Framing error: frame 0x33 with stop bit low, line held low 100 cycles, then high: no EN, DATA keeps its previous value; next frame 0x7E gives EN with DATA=0x7E.
- Reset mid-frame: pull RST_X low at data bit 4 of 0x41: DATA=0x00 and EN=0 immediately with no clock edge; after release with RXD high, frame 0x42 is received correctly.
- SERIALC_SYNC_EN defined: send 0x41 with EN at cycle 193 relative to the RXD start edge, DATA=0x41.
